// File: rtl/adder_share_pkg.sv
// Shared definitions for the round-robin shared adder slice.
//   DATA_W       operand / sum width
//   ID_MAX_W     widest requester ID supported (N_REQ up to 8)
//   rsp_entry_t  one tagged result as held in the response FIFO
//   rr_next_ptr  round-robin pointer advance after a grant
package adder_share_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ID_MAX_W = 3;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [DATA_W-1:0]   sum;
        logic                cout;
    } rsp_entry_t;

    // The granted requester becomes lowest priority on the next scan.
    function automatic int unsigned rr_next_ptr(input int unsigned grant_idx,
                                                input int unsigned n_req);
        return (grant_idx + 32'd1 >= n_req) ? 32'd0 : grant_idx + 32'd1;
    endfunction

endpackage

// File: rtl/adder_ripple_8u.sv
// 8-bit unsigned ripple-carry adder, purely combinational.
//   a, b  operands
//   cin   carry in
//   sum   a + b + cin, low 8 bits
//   cout  carry out of bit 7
module adder_ripple_8u (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    assign carry[0] = cin;

    for (genvar g = 0; g < 8; g++) begin : g_bit
        assign sum[g]     = a[g] ^ b[g] ^ carry[g];
        assign carry[g+1] = (a[g] & b[g]) | (carry[g] & (a[g] ^ b[g]));
    end

    assign cout = carry[8];

endmodule

// File: rtl/adder_share_rsp_fifo.sv
// Show-ahead response FIFO holding tagged adder results.
//   clk, rst  clock, synchronous active-high reset
//   wr_en     push wr_data
//   wr_data   entry to store
//   rd_en     consumer accepts head (ignored when empty)
//   rd_valid  head entry present
//   rd_data   head entry, zero when empty
//   count     current number of stored entries
module adder_share_rsp_fifo
    import adder_share_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  rsp_entry_t                 wr_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output rsp_entry_t                 rd_data,
    output logic [$clog2(RSP_DEPTH):0] count
);

    localparam int unsigned AW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = AW + 1;

    rsp_entry_t    mem_q [RSP_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = rd_en && (count_q != '0);
        // A push into a full FIFO is only taken when the head leaves in the same cycle.
        do_push  = wr_en && ((count_q != CW'(RSP_DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        rd_valid = (count_q != '0);
        rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
        count    = count_q;
    end

endmodule

// File: rtl/adder_rr_share.sv
// One registered 8-bit adder shared by N_REQ requesters through a
// round-robin arbiter, a 2-stage pipeline and a credit-protected
// response FIFO.
//   clk, rst   clock, synchronous active-high reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept, one-hot or zero
//   req_a/b    packed operands, requester i at [8i+7:8i]
//   rsp_valid  FIFO head valid
//   rsp_ready  consumer accepts head
//   rsp_id     requester index of head result
//   rsp_sum    head sum (a+b mod 256)
//   rsp_cout   head carry out
//   busy       pipeline or FIFO holds work
module adder_rr_share
    import adder_share_pkg::*;
#(
    parameter  int unsigned N_REQ     = 4,
    parameter  int unsigned RSP_DEPTH = 4,
    localparam int unsigned IDW       = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [DATA_W*N_REQ-1:0] req_a,
    input  logic [DATA_W*N_REQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [DATA_W-1:0]       rsp_sum,
    output logic                    rsp_cout,
    output logic                    busy
);

    localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned FW = CW + 1;

    logic [DATA_W-1:0] a_arr [N_REQ];
    logic [DATA_W-1:0] b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*DATA_W +: DATA_W];
        assign b_arr[g] = req_b[g*DATA_W +: DATA_W];
    end

    logic [IDW-1:0]    ptr_q, ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic [IDW-1:0]    s1_id_q, s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    rsp_entry_t        s2_ent_q, s2_ent_d;

    logic [N_REQ-1:0]  grant;
    logic [IDW-1:0]    gidx;
    logic [IDW-1:0]    scan_idx;
    logic              found;
    logic [FW-1:0]     inflight;
    logic              credit_ok;
    logic [CW-1:0]     fifo_count;
    logic              fifo_valid;
    rsp_entry_t        head;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              unused_head_id;

    // Every accepted operand pair holds a credit until its result is popped,
    // so the FIFO always has room for whatever is in the pipeline.
    always_comb begin
        inflight  = FW'(s1_valid_q) + FW'(s2_valid_q) + FW'(fifo_count);
        credit_ok = (inflight < FW'(RSP_DEPTH));
    end

    always_comb begin
        grant    = '0;
        gidx     = '0;
        scan_idx = '0;
        found    = 1'b0;
        if (credit_ok && !rst) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                scan_idx = IDW'((32'(ptr_q) + k) % N_REQ);
                if (!found && req_valid[scan_idx]) begin
                    found           = 1'b1;
                    gidx            = scan_idx;
                    grant[scan_idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d        = found ? IDW'(rr_next_ptr(32'(gidx), N_REQ)) : ptr_q;
        s1_valid_d   = found;
        s1_a_d       = a_arr[gidx];
        s1_b_d       = b_arr[gidx];
        s1_id_d      = gidx;
        s2_valid_d   = s1_valid_q;
        s2_ent_d     = '0;
        s2_ent_d.id  = ID_MAX_W'(s1_id_q);
        s2_ent_d.sum = add_sum;
        s2_ent_d.cout = add_cout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_ent_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_ent_q   <= s2_ent_d;
        end
    end

    adder_ripple_8u u_adder (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    adder_share_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (s2_valid_q),
        .wr_data  (s2_ent_q),
        .rd_en    (rsp_ready),
        .rd_valid (fifo_valid),
        .rd_data  (head),
        .count    (fifo_count)
    );

    always_comb begin
        req_ready      = grant;
        rsp_valid      = fifo_valid;
        rsp_id         = head.id[IDW-1:0];
        rsp_sum        = head.sum;
        rsp_cout       = head.cout;
        busy           = s1_valid_q | s2_valid_q | (fifo_count != '0);
        unused_head_id = ^head.id;
    end

endmodule

// File: tb/tb_adder_rr_share.sv
module tb_adder_rr_share;

    localparam int N = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a = '0;
    logic [8*N-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_sum;
    logic           rsp_cout;
    logic           busy;

    typedef struct {
        int id;
        int sum;
        int cout;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   mptr    = 0;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   acc_cnt = 0;

    adder_rr_share #(
        .N_REQ     (N),
        .RSP_DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model of the arbiter and credit rule: a result is owed for every
    // accepted pair not yet popped, and at most D may be owed.
    task automatic score();
        logic [N-1:0] exp_rdy;
        int gid;
        int s;
        if (rst) begin
            sbq.delete();
            mptr = 0;
            return;
        end
        exp_rdy = '0;
        gid     = -1;
        if (sbq.size() < D) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (mptr + k) % N;
                if (gid < 0 && req_valid[i]) gid = i;
            end
        end
        if (gid >= 0) exp_rdy = N'(1) << gid;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(sbq.size() != 0));
        if (req_ready != '0) acc_cnt++;
        if (gid >= 0) begin
            s = int'(req_a[gid*8 +: 8]) + int'(req_b[gid*8 +: 8]);
            sbq.push_back('{gid, s % 256, s / 256, cyc});
            mptr = (gid + 1) % N;
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rr, input logic r,
                         input logic [8*N-1:0] a, input logic [8*N-1:0] b);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        rsp_ready = rr;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        score();
    endtask

    function automatic logic [8*N-1:0] rnd();
        return (8*N)'($urandom);
    endfunction

    task automatic drain();
        for (int i = 0; i < 60 && sbq.size() != 0; i++) drive('0, 1'b1, 1'b0, rnd(), rnd());
        chk("drain_done", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: a result is visible three cycles after its acceptance at the
    // earliest, and always in acceptance order.
    initial begin
        forever begin
            logic ev;
            @(negedge clk);
            #2;
            if (!rst) begin
                ev = (sbq.size() > 0) && (sbq[0].cyc + 3 <= cyc);
                chk("rsp_valid", 32'(rsp_valid), 32'(ev));
                if (ev) begin
                    chk("rsp_id",   32'(rsp_id),   32'(sbq[0].id));
                    chk("rsp_sum",  32'(rsp_sum),  32'(sbq[0].sum));
                    chk("rsp_cout", 32'(rsp_cout), 32'(sbq[0].cout));
                    if (rsp_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        int g0;

        repeat (2) drive('0, 1'b0, 1'b1, '0, '0);
        drive('0, 1'b0, 1'b0, '0, '0);
        chk("rst_rsp_id",   32'(rsp_id),   32'd0);
        chk("rst_rsp_sum",  32'(rsp_sum),  32'd0);
        chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);

        // Single request and carry cases
        drive(4'b0001, 1'b1, 1'b0, 32'h0000_0012, 32'h0000_0034);
        repeat (5) drive('0, 1'b1, 1'b0, rnd(), rnd());
        drive(4'b0100, 1'b1, 1'b0, 32'h00FF_0000, 32'h0001_0000);
        drive(4'b0100, 1'b1, 1'b0, 32'h0080_0000, 32'h0080_0000);
        repeat (5) drive('0, 1'b1, 1'b0, rnd(), rnd());

        // Fairness with all requesters valid
        g0 = 0;
        for (int i = 0; i < 16; i++) begin
            drive(4'hF, 1'b1, 1'b0, rnd(), rnd());
            if (req_ready[0]) g0++;
        end
        chk("fair_req0_grants", 32'(g0), 32'd4);
        drain();

        // Backpressure: credits stop acceptance at D outstanding
        acc_cnt = 0;
        repeat (10) drive(4'hF, 1'b0, 1'b0, rnd(), rnd());
        chk("bp_accepts", 32'(acc_cnt), 32'(D));
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_ready_zero", 32'(req_ready), 32'd0);
        acc_cnt = 0;
        drive(4'hF, 1'b1, 1'b0, rnd(), rnd());
        repeat (5) drive(4'hF, 1'b0, 1'b0, rnd(), rnd());
        chk("bp_one_more", 32'(acc_cnt), 32'd1);

        // Pop in the same cycle a stage-2 result is written with credits exhausted
        drive(4'hF, 1'b1, 1'b0, rnd(), rnd());
        drive(4'hF, 1'b0, 1'b0, rnd(), rnd());
        drive(4'hF, 1'b0, 1'b0, rnd(), rnd());
        drive(4'hF, 1'b1, 1'b0, rnd(), rnd());
        repeat (4) drive(4'hF, 1'b0, 1'b0, rnd(), rnd());
        drain();

        // Randomised traffic
        repeat (400) drive(N'($urandom), ($urandom_range(0, 3) != 0), 1'b0, rnd(), rnd());
        drain();

        // Reset with two results queued and two in the pipeline
        drive(4'b0001, 1'b0, 1'b0, rnd(), rnd());
        drive(4'b0010, 1'b0, 1'b0, rnd(), rnd());
        drive('0, 1'b0, 1'b0, rnd(), rnd());
        drive('0, 1'b0, 1'b0, rnd(), rnd());
        drive(4'b0100, 1'b0, 1'b0, rnd(), rnd());
        drive(4'b1000, 1'b0, 1'b0, rnd(), rnd());
        drive('0, 1'b0, 1'b1, rnd(), rnd());
        drive('0, 1'b1, 1'b0, rnd(), rnd());
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        repeat (6) drive('0, 1'b1, 1'b0, rnd(), rnd());
        drive(4'hF, 1'b1, 1'b0, rnd(), rnd());
        chk("post_rst_ptr", 32'(req_ready), 32'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
